// File: rtl/simd_pkg.sv
// simd_pkg: opcode encoding and shared constants for the SIMD issue path.
// Contents:
//   opcode_e     - lane operation encoding driven onto simd_core
//   OP_LAST      - highest legal opcode value
//   ILLEGAL_FILL - per-lane value simd_core returns for an illegal opcode
//   is_legal_op  - 1 when an opcode is one the core implements
package simd_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_MUL = 3'd4
  } opcode_e;

  localparam logic [2:0]  OP_LAST      = 3'd4;
  localparam logic [31:0] ILLEGAL_FILL = 32'hDEADBEEF;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N eligible requesters.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   eligible   - per-requester eligibility for this cycle
//   grant      - one-hot grant (all zero when nobody is eligible)
//   grant_idx  - index of the granted requester (0 when no grant)
//   grant_any  - 1 when some requester is granted this cycle
// The pointer holds the last granted index; the search starts one past it,
// so after reset (pointer = N-1) requester 0 has top priority.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  eligible,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr_r;

  // Search upward from ptr+1 with wrap; the first eligible requester wins.
  always_comb begin
    int c;
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr_r) + k;
      if (c >= N) begin
        c = c - N;
      end else begin
        c = c;
      end
      if (!grant_any && eligible[c[IW-1:0]]) begin
        grant_any               = 1'b1;
        grant_idx               = c[IW-1:0];
        grant[c[IW-1:0]]        = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Pointer register: remembers the most recent winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= IW'(N - 1);
    end else if (grant_any) begin
      ptr_r <= grant_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/simd_issue_arbiter.sv
// simd_issue_arbiter: shares one simd_core between NREQ vector requesters.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake per requester (ready = grant)
//   req_opcode/req_a/req_b       - per-requester operation and operand vectors
//   core_opcode/core_a/core_b    - registered operation presented to simd_core
//   core_r                       - simd_core result (one cycle after core_* change)
//   rsp_valid/rsp_ready          - per-requester response handshake
//   rsp_data/rsp_err             - lane results and illegal-opcode flag
//   issued_cnt                   - grants since reset, wraps modulo 2^CNTW
// Flow: grant in cycle t -> core_* at t+1 (S1) -> core_r at t+2 (S2) ->
// captured into the owner's response buffer, visible from t+3.
module simd_issue_arbiter
  import simd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int NREQ  = 2,
  parameter int CNTW  = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NREQ-1:0]                            req_valid,
  output logic [NREQ-1:0]                            req_ready,
  input  logic [NREQ-1:0][2:0]                       req_opcode,
  input  logic signed [NREQ-1:0][LANES-1:0][WIDTH-1:0] req_a,
  input  logic signed [NREQ-1:0][LANES-1:0][WIDTH-1:0] req_b,
  output logic [2:0]                                 core_opcode,
  output logic signed [LANES-1:0][WIDTH-1:0]         core_a,
  output logic signed [LANES-1:0][WIDTH-1:0]         core_b,
  input  logic signed [LANES-1:0][WIDTH-1:0]         core_r,
  output logic [NREQ-1:0]                            rsp_valid,
  input  logic [NREQ-1:0]                            rsp_ready,
  output logic signed [NREQ-1:0][LANES-1:0][WIDTH-1:0] rsp_data,
  output logic [NREQ-1:0]                            rsp_err,
  output logic [CNTW-1:0]                            issued_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic            s1_valid_r, s2_valid_r;
  logic [IW-1:0]   s1_id_r, s2_id_r;
  logic            s1_err_r, s2_err_r;
  logic [NREQ-1:0] busy_s, eligible_s, grant_s;
  logic [IW-1:0]   grant_idx_s;
  logic            grant_any_s;

  // A requester with an op in S1/S2 or an unconsumed response may not issue,
  // which guarantees its response buffer is free at capture time.
  always_comb begin
    busy_s = rsp_valid;
    if (s1_valid_r) begin
      busy_s = busy_s | (ONE_HOT0 << s1_id_r);
    end else begin
      busy_s = busy_s;
    end
    if (s2_valid_r) begin
      busy_s = busy_s | (ONE_HOT0 << s2_id_r);
    end else begin
      busy_s = busy_s;
    end
    if (rst) begin
      eligible_s = '0;
    end else begin
      eligible_s = req_valid & ~busy_s;
    end
  end

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .eligible  (eligible_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign req_ready = grant_s;

  // Issue stage (S1) and in-flight tracking through the core latency (S2).
  always_ff @(posedge clk) begin
    if (rst) begin
      core_opcode <= 3'd0;
      core_a      <= '0;
      core_b      <= '0;
      s1_valid_r  <= 1'b0;
      s1_id_r     <= '0;
      s1_err_r    <= 1'b0;
      s2_valid_r  <= 1'b0;
      s2_id_r     <= '0;
      s2_err_r    <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      if (grant_any_s) begin
        core_opcode <= req_opcode[grant_idx_s];
        core_a      <= req_a[grant_idx_s];
        core_b      <= req_b[grant_idx_s];
        s1_valid_r  <= 1'b1;
        s1_id_r     <= grant_idx_s;
        s1_err_r    <= !is_legal_op(req_opcode[grant_idx_s]);
        issued_cnt  <= issued_cnt + CNTW'(1);
      end else begin
        core_opcode <= core_opcode;
        core_a      <= core_a;
        core_b      <= core_b;
        s1_valid_r  <= 1'b0;
        s1_id_r     <= s1_id_r;
        s1_err_r    <= s1_err_r;
        issued_cnt  <= issued_cnt;
      end
      s2_valid_r <= s1_valid_r;
      s2_id_r    <= s1_id_r;
      s2_err_r   <= s1_err_r;
    end
  end

  // Per-requester response buffers: capture from S2, hold until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (s2_valid_r && (s2_id_r == IW'(i))) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[i]  <= core_r;
          rsp_err[i]   <= s2_err_r;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end else begin
          rsp_valid[i] <= rsp_valid[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_issue_arbiter.sv
// tb_simd_issue_arbiter: randomized + directed bench with a scoreboard.
// A tracker predicts grants from the round-robin rules and pushes expected
// responses; a monitor pops and compares them whenever responses appear.
// simd_core is modelled as a one-cycle registered lane ALU.
module tb_simd_issue_arbiter;
  import simd_pkg::*;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int NREQ  = 2;
  localparam int CNTW  = 4;

  typedef logic signed [LANES-1:0][WIDTH-1:0] vec_t;
  typedef struct {
    vec_t data;
    logic err;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0][2:0] req_opcode = '0;
  logic signed [NREQ-1:0][LANES-1:0][WIDTH-1:0] req_a = '0;
  logic signed [NREQ-1:0][LANES-1:0][WIDTH-1:0] req_b = '0;
  logic [2:0] core_opcode;
  vec_t core_a, core_b;
  vec_t core_r = '0;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready = '1;
  logic signed [NREQ-1:0][LANES-1:0][WIDTH-1:0] rsp_data;
  logic [NREQ-1:0] rsp_err;
  logic [CNTW-1:0] issued_cnt;

  simd_issue_arbiter #(.WIDTH(WIDTH), .LANES(LANES), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .core_opcode(core_opcode), .core_a(core_a), .core_b(core_b), .core_r(core_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LANES*WIDTH-1:0] act,
                     input logic [LANES*WIDTH-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Lane semantics of simd_core, written directly from the opcode table.
  function automatic vec_t ref_op(input logic [2:0] op, input vec_t a, input vec_t b);
    vec_t r;
    for (int l = 0; l < LANES; l++) begin
      logic signed [WIDTH-1:0] x, y;
      x = a[l];
      y = b[l];
      case (op)
        3'd0:    r[l] = x + y;
        3'd1:    r[l] = x - y;
        3'd2:    r[l] = x & y;
        3'd3:    r[l] = x | y;
        3'd4:    r[l] = x * y;
        default: r[l] = ILLEGAL_FILL;
      endcase
    end
    return r;
  endfunction

  // simd_core stand-in: one registered cycle of latency.
  always @(posedge clk) core_r <= ref_op(core_opcode, core_a, core_b);

  // Reference model state.
  int   granted [NREQ];
  int   done_n  [NREQ];
  int   last_g = NREQ - 1;
  int   exp_issued = 0;
  bit   rst_seen = 1'b0;
  exp_t sb [NREQ][$];

  // Tracker: predicts req_ready, issued_cnt and reset state; pushes expectations.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int w;
    exp_t e;
    w = -1;
    exp_ready = '0;
    if (rst_seen) begin
      chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
      chk("reset_rsp_err", 128'(rsp_err), 128'd0);
      chk("reset_rsp_data", 128'(rsp_data), 128'd0);
      chk("reset_core_opcode", 128'(core_opcode), 128'd0);
      chk("reset_core_a", core_a, 128'd0);
      chk("reset_core_b", core_b, 128'd0);
    end
    chk("issued_cnt", 128'(issued_cnt), 128'(exp_issued));
    if (rst) begin
      last_g = NREQ - 1;
      exp_issued = 0;
      for (int i = 0; i < NREQ; i++) granted[i] = 0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (last_g + k) % NREQ;
        if (w < 0 && req_valid[j] && granted[j] == done_n[j]) w = j;
      end
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    if (w >= 0) begin
      last_g = w;
      exp_issued = (exp_issued + 1) % (1 << CNTW);
      granted[w]++;
      e.data = ref_op(req_opcode[w], req_a[w], req_b[w]);
      e.err  = (req_opcode[w] > 3'd4);
      e.due  = cyc + 3;
      sb[w].push_back(e);
    end
  end

  // Monitor: runs just after the tracker; compares responses against the queue.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        sb[i].delete();
        done_n[i] = 0;
      end else if (sb[i].size() == 0) begin
        chk("rsp_spurious", 128'(rsp_valid[i]), 128'd0);
      end else if (cyc < sb[i][0].due) begin
        chk("rsp_early", 128'(rsp_valid[i]), 128'd0);
      end else begin
        chk("rsp_valid", 128'(rsp_valid[i]), 128'd1);
        if (rsp_valid[i]) begin
          chk("rsp_data", rsp_data[i], sb[i][0].data);
          chk("rsp_err", 128'(rsp_err[i]), 128'(sb[i][0].err));
          if (rsp_ready[i]) begin
            void'(sb[i].pop_front());
            done_n[i]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] acc;

  task automatic step();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkvec(input int l0, input int l1, input int l2, input int l3);
    vec_t v;
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
    return v;
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    for (int l = 0; l < LANES; l++)
      v[l] = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 200)) - WIDTH'(100)
                                         : WIDTH'($urandom());
    return v;
  endfunction

  task automatic drive(input int i, input logic [2:0] op, input vec_t a, input vec_t b);
    req_valid[i]  = 1'b1;
    req_opcode[i] = op;
    req_a[i]      = a;
    req_b[i]      = b;
  endtask

  task automatic wait_accept(input int i);
    for (int n = 0; n < 40; n++) begin
      step();
      if (acc[i]) break;
    end
    chk("accept", 128'(acc[i]), 128'd1);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int g0, g1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // 1: single ADD from requester 0
    drive(0, OP_ADD, mkvec(1, 2, 3, 4), mkvec(10, 20, 30, 40));
    wait_accept(0);
    repeat (4) step();
    chk("t1_data", rsp_data[0], mkvec(11, 22, 33, 44));
    chk("t1_issued", 128'(issued_cnt), 128'd1);

    // 2: both requesters continuously active
    g0 = 0; g1 = 0;
    drive(0, OP_ADD, rvec(), rvec());
    drive(1, OP_SUB, rvec(), rvec());
    for (int c = 0; c < 24; c++) begin
      step();
      g0 += int'(acc[0]);
      g1 += int'(acc[1]);
      if (acc[0]) drive(0, OP_ADD, rvec(), rvec());
      if (acc[1]) drive(1, OP_SUB, rvec(), rvec());
    end
    req_valid = '0;
    chk("t2_grants0", 128'(g0), 128'd6);
    chk("t2_grants1", 128'(g1), 128'd6);
    repeat (6) step();

    // 3: MUL with a stalled consumer
    rsp_ready[1] = 1'b0;
    drive(1, OP_MUL, mkvec(-3, 5, 0, 7), mkvec(4, -6, 9, 7));
    wait_accept(1);
    drive(1, OP_OR, rvec(), rvec());
    repeat (8) step();
    chk("t3_hold_valid", 128'(rsp_valid[1]), 128'd1);
    chk("t3_hold_data", rsp_data[1], mkvec(-12, -30, 0, 49));
    rsp_ready[1] = 1'b1;
    wait_accept(1);
    repeat (5) step();

    // 4: illegal opcode then a SUB
    drive(0, 3'b111, rvec(), rvec());
    wait_accept(0);
    repeat (2) step();
    chk("t4_err", 128'(rsp_err[0]), 128'd1);
    chk("t4_fill", rsp_data[0], {4{ILLEGAL_FILL}});
    drive(0, OP_SUB, mkvec(5, 5, 5, 5), mkvec(1, 2, 3, 4));
    wait_accept(0);
    repeat (5) step();
    chk("t4_sub", rsp_data[0], mkvec(4, 3, 2, 1));
    chk("t4_sub_err", 128'(rsp_err[0]), 128'd0);

    // 5: reset one cycle after a grant
    drive(1, OP_ADD, rvec(), rvec());
    wait_accept(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, OP_AND, rvec(), rvec());
    drive(1, OP_OR, rvec(), rvec());
    step();
    chk("t5_first_grant", 128'(acc), 128'd1);
    req_valid[0] = 1'b0;
    wait_accept(1);
    repeat (6) step();

    // random phase
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 99) < 70) drive(i, 3'($urandom_range(0, 7)), rvec(), rvec());
          else req_valid[i] = 1'b0;
        end
      end
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (8) step();

    // 6: counter wrap after 17 grants
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 17; n++) begin
      drive(n % 2, OP_ADD, rvec(), rvec());
      wait_accept(n % 2);
    end
    chk("t6_wrap", 128'(issued_cnt), 128'd1);
    repeat (6) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/simd_issue_arbiter.md
Name: simd_issue_arbiter

Overview:
- Shares one simd_core instance between NREQ requesters.
- Arbitrates round-robin and registers the winning opcode and operands onto the core inputs.
- Tracks the in-flight operation through the core's 1-cycle registered latency, then routes the lane results back to the owning requester through a per-requester response buffer with valid/ready.
- Sits between the vector front-ends and simd_core.

Parameters:
WIDTH, 32, lane data width (matches simd_core)
LANES, 4, lanes per vector (matches simd_core)
NREQ, 2, number of requesters; legal range 2..8
CNTW, 16, width of issued-operation counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  [NREQ]  request pending per requester
req_ready  out  [NREQ]  grant; request accepted when valid&ready
req_opcode  in  [NREQ][3]  opcode per requester
req_a  in  [NREQ][LANES][WIDTH] signed  operand A vectors
req_b  in  [NREQ][LANES][WIDTH] signed  operand B vectors
core_opcode  out  3  to simd_core opcode
core_a  out  [LANES][WIDTH] signed  to simd_core A
core_b  out  [LANES][WIDTH] signed  to simd_core B
core_r  in  [LANES][WIDTH] signed  from simd_core R
rsp_valid  out  [NREQ]  response available
rsp_ready  in  [NREQ]  response consumed when valid&ready
rsp_data  out  [NREQ][LANES][WIDTH] signed  lane results
rsp_err  out  [NREQ]  operation had illegal opcode (>4)
issued_cnt  out  CNTW  total grants since reset, wraps modulo 2^CNTW

Behaviour:
- Reset: clk, rst single clock domain; reset is synchronous, active-high. On rst, all of the following clear the next edge:
  - rsp_valid, rsp_err, rsp_data = 0
  - core_opcode = 0, core_a = core_b = 0
  - issued_cnt = 0
  - stage valids = 0
  - RR pointer = NREQ-1, so requester 0 has top priority first
- req_ready is 0 during the rst cycle. Reset mid-operation discards in-flight ops and pending responses; no response is ever produced for them.
- busy[i] = (op owned by i in S1 or S2) | rsp_valid[i]. Requester i is eligible iff req_valid[i] & !busy[i]. At most one outstanding op per requester.
- Arbitration (combinational): among eligible requesters, grant the first one searching from ptr+1 upward with wrap. req_ready is one-hot or zero. On a grant, ptr <= granted index; otherwise ptr holds.
- Pipeline, grant in cycle t:
  - S1 (edge end of t): core_opcode/core_a/core_b <= winner's fields; s1_valid=1, s1_id=i, s1_err = (opcode > 3'b100). With no grant, core_* hold and s1_valid=0.
  - S2 (edge end of t+1): simd_core registers R; s2_valid/s2_id/s2_err follow S1.
  - Capture (edge end of t+2): if s2_valid, rsp_data[s2_id] <= core_r, rsp_err[s2_id] <= s2_err, rsp_valid[s2_id] <= 1.
  - rsp_valid is high from cycle t+3. Grant-to-response latency is 3 cycles.
- The response buffer is guaranteed free at capture because busy blocks reissue. rsp_valid/rsp_data/rsp_err stay stable until rsp_ready is sampled high; rsp_valid clears the following edge.
- Earliest re-grant to the same requester: the cycle after its response handshake. With all NREQ requesters continuously active and consumers always ready, a grant occurs every cycle once NREQ ≥ 4; with NREQ=2, each requester is granted every 4 cycles.
- Illegal opcode: issued normally. Core returns 32'hDEADBEEF per lane; rsp_err=1.
- issued_cnt increments by 1 on each grant edge; wraps from 2^CNTW-1 to 0.
- Simultaneous rsp handshake and new req_valid for the same requester: the requester is busy this cycle, so it is eligible the next cycle.

Decomposition:
- simd_pkg:
  - opcode enum: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_MUL=4
  - OP_LAST=4
  - ILLEGAL_FILL=32'hDEADBEEF
  - function is_legal_op
- Sub-module rr_arbiter #(N): eligible vector and pointer in, one-hot grant and granted index out. Pointer register lives in rr_arbiter.

Test Plan:
1. After reset, req0 ADD A={1,2,3,4}, B={10,20,30,40}, rsp_ready=1 -> req_ready[0] in cycle 0; rsp_valid[0] in cycle 3, data {11,22,33,44}, err=0; issued_cnt=1.
2. Both requesters valid every cycle, rsp_ready=1, NREQ=2 -> grants 0,1 alternate; each requester granted once per 4 cycles; never both in one cycle.
3. req1 MUL A={-3,5,0,7}, B={4,-6,9,7}, rsp_ready held 0 for 5 cycles -> rsp_valid[1] and data {-12,-30,0,49} stay stable; req_ready[1]=0 throughout; re-grant the cycle after release.
4. req0 opcode 3'b111 -> rsp_data[0]=4×32'hDEADBEEF, rsp_err[0]=1; a following SUB {5,5,5,5}-{1,2,3,4} -> {4,3,2,1}, err=0.
5. Assert rst one cycle after a grant -> no rsp_valid ever appears for that op; all outputs 0; the next grant goes to requester 0.
6. CNTW=4, 17 grants -> issued_cnt reads 1 (wrapped).
